ext_sram_dma: RTL and testbench
===============================

Name: ext_sram_dma

Overview:
- Request initiator for the external SRAM valid/ready read and write ports (W0_*/R0_*).
- Copies a block of 32-bit words in either direction between external SRAM and a local 1024-word single-port buffer.
- Local buffer has one-cycle registered read latency (en/wmode/addr/wdata/rdata).
- Sits between the core's block-move command interface and the external memory model; one command at a time.

Parameters:
- EXT_AW, 26, external word-address width.
- LOC_AW, 10, local buffer word-address width (depth 2^LOC_AW).
- DW, 32, data width.

Ports:
- clk  in  1  single clock; also drives the external SRAM's W0_clk and R0_clk.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command offer.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready at a clk edge.
- cmd_dir  in  1  0 = LOAD (ext->local), 1 = STORE (local->ext).
- cmd_ext_addr  in  EXT_AW  external start word address.
- cmd_loc_addr  in  LOC_AW  local start word address.
- cmd_len  in  LOC_AW+1  word count; 0 = no-op; values above 2^LOC_AW are clamped to 2^LOC_AW.
- busy  out  1  high from acceptance until done.
- done  out  1  one-cycle pulse at command completion.
- R0_addr  out  EXT_AW  read address.
- R0_valid  out  1  read request.
- R0_ready  in  1  read-complete pulse.
- R0_data  in  DW  read data.
- W0_addr  out  EXT_AW  write address.
- W0_data  out  DW  write data.
- W0_valid  out  1  write request.
- W0_ready  in  1  write-complete pulse.
- loc_addr  out  LOC_AW  local buffer address.
- loc_en  out  1  local buffer enable.
- loc_wmode  out  1  local buffer write mode.
- loc_wdata  out  DW  local buffer write data.
- loc_rdata  in  DW  local buffer read data.

Behaviour:
- All outputs are registered.
- Reset values: everything 0, except cmd_ready = 1. State = IDLE; counters and pointers cleared.
- Reset asserted mid-transfer:
  - R0_valid, W0_valid and loc_en drop immediately (asynchronously).
  - The transfer is abandoned and no done pulse is issued.
- External handshake rules:
  - The valid output rises together with a stable addr and data.
  - addr and data are held unchanged while valid is high.
  - ready is a one-cycle pulse of unknown latency (≥1).
  - At the edge where ready is sampled high, the valid output is cleared.
  - Valid stays low for at least one full cycle before the next request.
  - R0_data is sampled in the R0_ready cycle.
  - R0_valid and W0_valid are never high together.
- States: IDLE, LD_REQ, LD_WR, ST_RD, ST_CAP, ST_REQ, GAP, DONE.
- IDLE:
  - On accept: latch the pointers and remaining = min(cmd_len, 2^LOC_AW).
  - If remaining is 0, go to DONE.
  - Otherwise go to LD_REQ (dir=0) or ST_RD (dir=1).
- LD_REQ: R0_valid = 1. On R0_ready: capture R0_data, clear R0_valid, go to LD_WR.
- LD_WR:
  - One cycle of loc_en = 1, loc_wmode = 1, loc_addr = loc pointer, loc_wdata = captured word.
  - Increment both pointers; decrement remaining.
  - Go to DONE if remaining reaches 0, else GAP, then LD_REQ.
- ST_RD: one cycle of loc_en = 1, loc_wmode = 0, loc_addr = loc pointer.
- ST_CAP: latch loc_rdata into W0_data; set W0_valid and W0_addr; go to ST_REQ.
- ST_REQ:
  - On W0_ready: clear W0_valid, increment pointers, decrement remaining.
  - Go to DONE, or GAP then ST_RD.
- GAP: one idle cycle with all request outputs low.
- DONE: done = 1 and busy = 0 for one cycle, then IDLE (cmd_ready = 1 the following cycle).
- Pointer wrap: the external pointer wraps mod 2^EXT_AW; the local pointer wraps mod 2^LOC_AW.
- cmd_valid is ignored while busy.
- A ready pulse while the corresponding valid is low is ignored.

Test Plan:
- Reset behaviour:
  - Stimulus: assert rst during ST_REQ of a STORE.
  - Required: W0_valid and loc_en are 0 in the same cycle; cmd_ready = 1 after release; no done pulse.
- LOAD of 4 words:
  - Stimulus: ext_addr 0x100, loc_addr 0x10, ext words 0xA0..0xA3, RD_LATENCY = 3.
  - Required: local[0x10..0x13] = 0xA0..0xA3; exactly 4 R0_valid bursts with addresses 0x100..0x103, each held until its R0_ready; one done pulse.
- STORE of 3 words:
  - Stimulus: local[0x3FE], [0x3FF], [0x000] = 1, 2, 3; ext_addr 0x3FFFFFF.
  - Required: ext[0x3FFFFFF] = 1, ext[0x0] = 2, ext[0x1] = 3 (both pointers wrap); W0_valid low for at least 1 cycle between writes.
- Zero-length and clamped commands:
  - cmd_len = 0 -> done exactly 2 cycles after accept, with no R0/W0/loc activity.
  - cmd_len = 2047 LOAD -> exactly 1024 local writes.
- Back-pressure and spurious ready:
  - Stimulus: hold cmd_valid while busy; inject a spurious R0_ready with R0_valid low.
  - Required: second command accepted only after done; the spurious pulse causes no capture or state change.

Source files
------------

// File: rtl/ext_sram_dma.sv
// rtl/ext_sram_dma.sv - block copier between external SRAM (R0/W0 valid/ready) and a local buffer
// One command at a time; every output is a register so the SRAM ports see glitch-free requests.
module ext_sram_dma #(
   parameter int EXT_AW = 26,
   parameter int LOC_AW = 10,
   parameter int DW     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [EXT_AW-1:0] cmd_ext_addr,
   input  logic [LOC_AW-1:0] cmd_loc_addr,
   input  logic [LOC_AW:0]   cmd_len,
   output logic              busy,
   output logic              done,
   output logic [EXT_AW-1:0] R0_addr,
   output logic              R0_valid,
   input  logic              R0_ready,
   input  logic [DW-1:0]     R0_data,
   output logic [EXT_AW-1:0] W0_addr,
   output logic [DW-1:0]     W0_data,
   output logic              W0_valid,
   input  logic              W0_ready,
   output logic [LOC_AW-1:0] loc_addr,
   output logic              loc_en,
   output logic              loc_wmode,
   output logic [DW-1:0]     loc_wdata,
   input  logic [DW-1:0]     loc_rdata
);

   typedef enum logic [2:0] {IDLE, LD_REQ, LD_WR, ST_RD, ST_CAP, ST_REQ, GAP, DONE} state_t;

   localparam logic [LOC_AW:0] MAX_LEN = {1'b1, {LOC_AW{1'b0}}};

   state_t            state;
   logic              dir;
   logic [EXT_AW-1:0] ext_ptr;
   logic [LOC_AW-1:0] loc_ptr;
   logic [LOC_AW:0]   remaining;
   logic              last;

   assign last = (remaining == (LOC_AW+1)'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         dir       <= 1'b0;
         ext_ptr   <= '0;
         loc_ptr   <= '0;
         remaining <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         R0_addr   <= '0;
         R0_valid  <= 1'b0;
         W0_addr   <= '0;
         W0_data   <= '0;
         W0_valid  <= 1'b0;
         loc_addr  <= '0;
         loc_en    <= 1'b0;
         loc_wmode <= 1'b0;
         loc_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               done      <= 1'b0;
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  dir       <= cmd_dir;
                  ext_ptr   <= cmd_ext_addr;
                  loc_ptr   <= cmd_loc_addr;
                  remaining <= (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
                  if (cmd_len == '0) begin
                     state <= DONE;
                  end else if (!cmd_dir) begin
                     state    <= LD_REQ;
                     R0_valid <= 1'b1;
                     R0_addr  <= cmd_ext_addr;
                  end else begin
                     state     <= ST_RD;
                     loc_en    <= 1'b1;
                     loc_wmode <= 1'b0;
                     loc_addr  <= cmd_loc_addr;
                  end
               end
            end
            LD_REQ: begin
               // The fetched word is held in loc_wdata until the buffer write cycle.
               if (R0_valid && R0_ready) begin
                  R0_valid  <= 1'b0;
                  loc_en    <= 1'b1;
                  loc_wmode <= 1'b1;
                  loc_addr  <= loc_ptr;
                  loc_wdata <= R0_data;
                  state     <= LD_WR;
               end
            end
            LD_WR: begin
               loc_en    <= 1'b0;
               loc_wmode <= 1'b0;
               ext_ptr   <= ext_ptr + EXT_AW'(1);
               loc_ptr   <= loc_ptr + LOC_AW'(1);
               remaining <= remaining - (LOC_AW+1)'(1);
               state     <= last ? DONE : GAP;
            end
            ST_RD: begin
               loc_en <= 1'b0;
               state  <= ST_CAP;
            end
            ST_CAP: begin
               W0_data  <= loc_rdata;
               W0_addr  <= ext_ptr;
               W0_valid <= 1'b1;
               state    <= ST_REQ;
            end
            ST_REQ: begin
               if (W0_valid && W0_ready) begin
                  W0_valid  <= 1'b0;
                  ext_ptr   <= ext_ptr + EXT_AW'(1);
                  loc_ptr   <= loc_ptr + LOC_AW'(1);
                  remaining <= remaining - (LOC_AW+1)'(1);
                  state     <= last ? DONE : GAP;
               end
            end
            GAP: begin
               // Requests for the next word launch from here so valid rises with its address.
               if (dir) begin
                  state     <= ST_RD;
                  loc_en    <= 1'b1;
                  loc_wmode <= 1'b0;
                  loc_addr  <= loc_ptr;
               end else begin
                  state    <= LD_REQ;
                  R0_valid <= 1'b1;
                  R0_addr  <= ext_ptr;
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ext_sram_dma.sv
// tb/tb_ext_sram_dma.sv - scoreboard bench for ext_sram_dma with SRAM and local buffer models
module tb_ext_sram_dma;
   localparam int EXT_AW = 26;
   localparam int LOC_AW = 10;
   localparam int DW = 32;
   localparam int RD_LATENCY = 3;
   localparam int WR_LATENCY = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_dir = 1'b0;
   logic [EXT_AW-1:0] cmd_ext_addr = '0;
   logic [LOC_AW-1:0] cmd_loc_addr = '0;
   logic [LOC_AW:0]   cmd_len = '0;
   logic              busy, done;
   logic [EXT_AW-1:0] R0_addr, W0_addr;
   logic              R0_valid, R0_ready, W0_valid, W0_ready;
   logic [DW-1:0]     R0_data, W0_data;
   logic [LOC_AW-1:0] loc_addr;
   logic              loc_en, loc_wmode;
   logic [DW-1:0]     loc_wdata, loc_rdata;

   always #5 clk = ~clk;

   ext_sram_dma #(.EXT_AW(EXT_AW), .LOC_AW(LOC_AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
      .cmd_ext_addr(cmd_ext_addr), .cmd_loc_addr(cmd_loc_addr), .cmd_len(cmd_len),
      .busy(busy), .done(done),
      .R0_addr(R0_addr), .R0_valid(R0_valid), .R0_ready(R0_ready), .R0_data(R0_data),
      .W0_addr(W0_addr), .W0_data(W0_data), .W0_valid(W0_valid), .W0_ready(W0_ready),
      .loc_addr(loc_addr), .loc_en(loc_en), .loc_wmode(loc_wmode),
      .loc_wdata(loc_wdata), .loc_rdata(loc_rdata)
   );

   int total = 0;
   int bad = 0;
   logic [DW-1:0] ext_mem [logic [EXT_AW-1:0]];
   logic [DW-1:0] loc_mem [0:(1<<LOC_AW)-1];
   logic [EXT_AW-1:0]        exp_r [$];
   logic [LOC_AW+DW-1:0]     exp_l [$];
   logic [EXT_AW+DW-1:0]     exp_w [$];
   int done_cnt = 0, r_hs = 0, w_hs = 0, loc_wr = 0, loc_act = 0, r_act = 0, w_act = 0;
   logic wr_hold = 1'b0;
   logic spurious_r = 1'b0;

   function automatic logic [DW-1:0] ext_rd(input logic [EXT_AW-1:0] a);
      if (ext_mem.exists(a)) return ext_mem[a];
      return {6'h15, a};
   endfunction

   // local buffer: one-cycle registered read
   initial begin
      logic en, wm;
      logic [LOC_AW-1:0] a;
      logic [DW-1:0] d;
      loc_rdata = '0;
      forever begin
         @(negedge clk);
         en = loc_en; wm = loc_wmode; a = loc_addr; d = loc_wdata;
         @(posedge clk);
         if (en && !rst) begin
            if (wm) loc_mem[a] = d;
            else loc_rdata = loc_mem[a];
         end
      end
   end

   // external SRAM responder
   initial begin
      int rd_wait, wr_wait;
      rd_wait = 0; wr_wait = 0;
      R0_ready = 1'b0; R0_data = '0; W0_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         R0_ready = 1'b0;
         W0_ready = 1'b0;
         if (rst) begin
            rd_wait = 0; wr_wait = 0;
         end else begin
            if (spurious_r) begin
               spurious_r = 1'b0;
               R0_ready = 1'b1;
               R0_data = 32'hDEAD_BEEF;
            end else if (R0_valid) begin
               if (rd_wait == RD_LATENCY-1) begin
                  rd_wait = 0; R0_ready = 1'b1; R0_data = ext_rd(R0_addr);
               end else rd_wait++;
            end else rd_wait = 0;
            if (W0_valid && !wr_hold) begin
               if (wr_wait == WR_LATENCY-1) begin
                  wr_wait = 0; W0_ready = 1'b1; ext_mem[W0_addr] = W0_data;
               end else wr_wait++;
            end else wr_wait = 0;
         end
      end
   end

   // monitor: protocol rules and scoreboard pops
   initial begin
      logic pr_v, pw_v, pr_hs, pw_hs;
      logic [EXT_AW-1:0] pr_a, pw_a, er;
      logic [DW-1:0] pw_d;
      logic [LOC_AW+DW-1:0] el;
      logic [EXT_AW+DW-1:0] ew;
      pr_v = 0; pw_v = 0; pr_hs = 0; pw_hs = 0; pr_a = '0; pw_a = '0; pw_d = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pr_v = 0; pw_v = 0; pr_hs = 0; pw_hs = 0;
         end else begin
            if (done) done_cnt++;
            if (loc_en) loc_act++;
            if (R0_valid) r_act++;
            if (W0_valid) w_act++;
            if (R0_valid || W0_valid) begin
               total++;
               if (R0_valid && W0_valid) begin bad++; $display("FAIL both_valid got=11 exp=not both"); end
            end
            if (pr_v && R0_valid) begin
               total++;
               if (R0_addr !== pr_a) begin bad++; $display("FAIL r_addr_hold got=%h exp=%h", R0_addr, pr_a); end
            end
            if (pw_v && W0_valid) begin
               total++;
               if ({W0_addr, W0_data} !== {pw_a, pw_d}) begin
                  bad++; $display("FAIL w_hold got=%h/%h exp=%h/%h", W0_addr, W0_data, pw_a, pw_d);
               end
            end
            if (pr_hs) begin
               total++;
               if (R0_valid !== 1'b0) begin bad++; $display("FAIL r_gap got=%b exp=0", R0_valid); end
            end
            if (pw_hs) begin
               total++;
               if (W0_valid !== 1'b0) begin bad++; $display("FAIL w_gap got=%b exp=0", W0_valid); end
            end
            if (R0_valid && R0_ready) begin
               r_hs++; total++;
               if (exp_r.size() == 0) begin bad++; $display("FAIL r_unexpected got=%h exp=none", R0_addr); end
               else begin
                  er = exp_r.pop_front();
                  if (R0_addr !== er) begin bad++; $display("FAIL r_addr got=%h exp=%h", R0_addr, er); end
               end
            end
            if (W0_valid && W0_ready) begin
               w_hs++; total++;
               if (exp_w.size() == 0) begin bad++; $display("FAIL w_unexpected got=%h/%h exp=none", W0_addr, W0_data); end
               else begin
                  ew = exp_w.pop_front();
                  if ({W0_addr, W0_data} !== ew) begin bad++; $display("FAIL w_xfer got=%h exp=%h", {W0_addr, W0_data}, ew); end
               end
            end
            if (loc_en && loc_wmode) begin
               loc_wr++; total++;
               if (exp_l.size() == 0) begin bad++; $display("FAIL l_unexpected got=%h/%h exp=none", loc_addr, loc_wdata); end
               else begin
                  el = exp_l.pop_front();
                  if ({loc_addr, loc_wdata} !== el) begin bad++; $display("FAIL l_write got=%h exp=%h", {loc_addr, loc_wdata}, el); end
               end
            end
            pr_v = R0_valid; pr_a = R0_addr; pr_hs = R0_valid && R0_ready;
            pw_v = W0_valid; pw_a = W0_addr; pw_d = W0_data; pw_hs = W0_valid && W0_ready;
         end
      end
   end

   task automatic issue(input logic dir, input logic [EXT_AW-1:0] ea, input logic [LOC_AW-1:0] la,
                        input logic [LOC_AW:0] len);
      int n;
      n = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_dir = dir; cmd_ext_addr = ea; cmd_loc_addr = la; cmd_len = len;
      while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_accept got=%b exp=1", cmd_ready); end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < budget) begin @(negedge clk); cycles++; end
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL done_timeout got=%b exp=1 after %0d", done, cycles); end
   endtask

   task automatic test_reset;
      int n, d0;
      repeat (3) @(negedge clk);
      total++;
      if ({cmd_ready, busy, done, R0_valid, W0_valid, loc_en, loc_wmode} !== 7'b1000000) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=1000000", {cmd_ready, busy, done, R0_valid, W0_valid, loc_en, loc_wmode});
      end
      total++;
      if ({R0_addr, W0_addr, W0_data, loc_addr, loc_wdata} !== '0) begin
         bad++; $display("FAIL reset_data got=%h exp=0", {R0_addr, W0_addr, W0_data, loc_addr, loc_wdata});
      end
      rst = 1'b0;
      loc_mem[0] = 32'h1234_5678; loc_mem[1] = 32'h9ABC_DEF0;
      wr_hold = 1'b1;
      d0 = done_cnt;
      issue(1'b1, 26'h10, 10'h0, 11'd2);
      n = 0;
      while (W0_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      total++;
      if (W0_valid !== 1'b1) begin bad++; $display("FAIL rst_reach_st_req got=%b exp=1", W0_valid); end
      rst = 1'b1;
      #1;
      total++;
      if ({W0_valid, loc_en, R0_valid, busy} !== 4'b0000) begin
         bad++; $display("FAIL rst_async got=%b exp=0000", {W0_valid, loc_en, R0_valid, busy});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wr_hold = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_release got=%b%b exp=10", cmd_ready, busy); end
      total++;
      if (done_cnt != d0) begin bad++; $display("FAIL rst_no_done got=%0d exp=%0d", done_cnt - d0, 0); end
   endtask

   task automatic test_load4;
      int cyc, d0, r0;
      d0 = done_cnt; r0 = r_hs;
      for (int i = 0; i < 4; i++) begin
         ext_mem[EXT_AW'(32'h100 + i)] = DW'(32'hA0 + i);
         exp_r.push_back(EXT_AW'(32'h100 + i));
         exp_l.push_back({LOC_AW'(16 + i), DW'(32'hA0 + i)});
      end
      issue(1'b0, 26'h100, 10'h10, 11'd4);
      wait_done(200, cyc);
      repeat (2) @(negedge clk);
      total++;
      if (r_hs - r0 != 4) begin bad++; $display("FAIL load4_bursts got=%0d exp=4", r_hs - r0); end
      total++;
      if (done_cnt - d0 != 1) begin bad++; $display("FAIL load4_done got=%0d exp=1", done_cnt - d0); end
      total++;
      if (exp_r.size() != 0 || exp_l.size() != 0) begin
         bad++; $display("FAIL load4_pending got=%0d/%0d exp=0/0", exp_r.size(), exp_l.size());
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (loc_mem[16 + i] !== DW'(32'hA0 + i)) begin
            bad++; $display("FAIL load4_local[%0d] got=%h exp=%h", 16 + i, loc_mem[16 + i], 32'hA0 + i);
         end
      end
   endtask

   task automatic test_store3;
      int cyc, d0;
      d0 = done_cnt;
      loc_mem[10'h3FE] = 32'd1; loc_mem[10'h3FF] = 32'd2; loc_mem[10'h000] = 32'd3;
      exp_w.push_back({26'h3FFFFFF, 32'd1});
      exp_w.push_back({26'h0000000, 32'd2});
      exp_w.push_back({26'h0000001, 32'd3});
      issue(1'b1, 26'h3FFFFFF, 10'h3FE, 11'd3);
      wait_done(200, cyc);
      repeat (2) @(negedge clk);
      total++;
      if (exp_w.size() != 0) begin bad++; $display("FAIL store3_pending got=%0d exp=0", exp_w.size()); end
      total++;
      if ({ext_rd(26'h3FFFFFF), ext_rd(26'h0), ext_rd(26'h1)} !== {32'd1, 32'd2, 32'd3}) begin
         bad++; $display("FAIL store3_ext got=%h %h %h exp=1 2 3", ext_rd(26'h3FFFFFF), ext_rd(26'h0), ext_rd(26'h1));
      end
      total++;
      if (done_cnt - d0 != 1) begin bad++; $display("FAIL store3_done got=%0d exp=1", done_cnt - d0); end
   endtask

   task automatic test_zero_clamp;
      int cyc, d0, ra, wa, la, lw;
      d0 = done_cnt; ra = r_act; wa = w_act; la = loc_act;
      issue(1'b0, 26'h55, 10'h5, 11'd0);
      wait_done(20, cyc);
      total++;
      if (cyc != 2) begin bad++; $display("FAIL zero_latency got=%0d exp=2", cyc); end
      repeat (2) @(negedge clk);
      total++;
      if (r_act != ra || w_act != wa || loc_act != la) begin
         bad++; $display("FAIL zero_activity got=%0d/%0d/%0d exp=0/0/0", r_act - ra, w_act - wa, loc_act - la);
      end
      total++;
      if (done_cnt - d0 != 1) begin bad++; $display("FAIL zero_done got=%0d exp=1", done_cnt - d0); end
      lw = loc_wr; d0 = done_cnt;
      for (int i = 0; i < 1024; i++) begin
         exp_r.push_back(EXT_AW'(32'h2000 + i));
         exp_l.push_back({LOC_AW'(i), ext_rd(EXT_AW'(32'h2000 + i))});
      end
      issue(1'b0, 26'h2000, 10'h0, 11'd2047);
      wait_done(20000, cyc);
      repeat (2) @(negedge clk);
      total++;
      if (loc_wr - lw != 1024) begin bad++; $display("FAIL clamp_writes got=%0d exp=1024", loc_wr - lw); end
      total++;
      if (exp_l.size() != 0 || exp_r.size() != 0) begin
         bad++; $display("FAIL clamp_pending got=%0d/%0d exp=0/0", exp_l.size(), exp_r.size());
      end
      total++;
      if (done_cnt - d0 != 1) begin bad++; $display("FAIL clamp_done got=%0d exp=1", done_cnt - d0); end
   endtask

   task automatic test_back_to_back;
      int n, d0, r0, la0, lw0, cyc;
      d0 = done_cnt;
      ext_mem[26'h300] = 32'h1111_0000; ext_mem[26'h301] = 32'h1111_0001;
      exp_r.push_back(26'h300); exp_r.push_back(26'h301);
      exp_l.push_back({10'h200, 32'h1111_0000}); exp_l.push_back({10'h201, 32'h1111_0001});
      issue(1'b0, 26'h300, 10'h200, 11'd2);
      cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_ext_addr = 26'h400; cmd_loc_addr = 10'h200; cmd_len = 11'd1;
      exp_w.push_back({26'h400, 32'h1111_0000});
      wr_hold = 1'b1;
      n = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      total++;
      if (cmd_ready !== 1'b1 || done_cnt != d0 + 1) begin
         bad++; $display("FAIL b2b_accept_order got=ready%b done%0d exp=ready1 done1", cmd_ready, done_cnt - d0);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = 0;
      while (W0_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      r0 = r_hs; la0 = loc_act; lw0 = loc_wr;
      spurious_r = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if ({W0_valid, busy, R0_valid} !== 3'b110 || r_hs != r0 || loc_act != la0 || loc_wr != lw0) begin
         bad++; $display("FAIL spurious_ready got=%b r%0d l%0d exp=110 r0 l0", {W0_valid, busy, R0_valid}, r_hs - r0, loc_act - la0);
      end
      wr_hold = 1'b0;
      wait_done(100, cyc);
      repeat (2) @(negedge clk);
      total++;
      if (exp_w.size() != 0 || ext_rd(26'h400) !== 32'h1111_0000) begin
         bad++; $display("FAIL b2b_store got=%h exp=11110000", ext_rd(26'h400));
      end
      total++;
      if (done_cnt - d0 != 2) begin bad++; $display("FAIL b2b_done got=%0d exp=2", done_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_load4();
      test_store3();
      test_zero_clamp();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
